sa_sequencer: RTL and testbench

Sequencing controller for the N×N systolic-array subsystem, clocked on `sys_clk`. It takes a job of M operand rows, pops them from the input FIFO into the array, and tracks each row through the array pipeline. It writes each result row to the output FIFO, then signals completion. All flow control is a single global stall (`arr_en`), so the array datapath needs no handshake of its own.

---
 rtl/sa_seq_if.sv | 28 ++
 rtl/sa_sequencer.sv | 146 ++++++++++++++
 tb/tb_sa_sequencer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sa_seq_if.sv
// sa_seq_if: bus bundle between the systolic-array sequencer and its
// input FIFO, array datapath and output FIFO; master = sequencer side.
interface sa_seq_if #(
  parameter int BW = 64
);
  logic          in_fifo_empty;
  logic [BW-1:0] in_fifo_dout;
  logic          in_fifo_rd;
  logic          arr_en;
  logic [BW-1:0] arr_din;
  logic          arr_din_vld;
  logic [BW-1:0] arr_dout;
  logic          out_fifo_full;
  logic          out_fifo_wr;
  logic [BW-1:0] out_fifo_din;

  modport master (
    input  in_fifo_empty, in_fifo_dout, arr_dout, out_fifo_full,
    output in_fifo_rd, arr_en, arr_din, arr_din_vld,
    output out_fifo_wr, out_fifo_din
  );

  modport slave (
    output in_fifo_empty, in_fifo_dout, arr_dout, out_fifo_full,
    input  in_fifo_rd, arr_en, arr_din, arr_din_vld,
    input  out_fifo_wr, out_fifo_din
  );
endinterface

// File: rtl/sa_sequencer.sv
// sa_sequencer: feeds M rows into an NxN systolic array, tracks them through
// the array with a valid shift register and writes results to the output FIFO.
// Ports: sys_clk, rst_n (async low), start/abort/M_minus_one job control,
// busy/done status, stall_cnt, bus (sa_seq_if.master: FIFOs + array).
// Option: define SA_SEQ_STALL_CNT_EN to build the saturating stall counter.
module sa_sequencer #(
  parameter int DIN_WIDTH = 8,
  parameter int N         = 4,
  parameter int BUS_WIDTH = 2*DIN_WIDTH*N,
  parameter int ARRAY_LAT = 2*N
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  M_minus_one,
  output logic        busy,
  output logic        done,
  output logic [15:0] stall_cnt,
  sa_seq_if.master    bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FEED  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [7:0]           m_last_q, m_last_d;
  logic [7:0]           fed_cnt_q, fed_cnt_d;
  logic [ARRAY_LAT-1:0] vld_sr_q, vld_sr_d;
  logic                 done_q, done_d;

  logic                 feed;
  logic                 drain;
  logic                 en;
  logic                 accept;
  logic [ARRAY_LAT-1:0] vld_shift;

  assign feed   = (state_q == S_FEED);
  assign drain  = (state_q == S_DRAIN);
  assign busy   = (state_q != S_IDLE);
  assign accept = (state_q == S_IDLE) && start && !abort;

  // One global stall: the array, the pop and the tracker move together.
  assign en = !abort && !bus.out_fifo_full &&
              (drain || (feed && !bus.in_fifo_empty));

  // Truncating cast drops the oldest bit; also valid for ARRAY_LAT == 1.
  assign vld_shift = ARRAY_LAT'({vld_sr_q, bus.arr_din_vld});

  assign bus.arr_en       = en;
  assign bus.in_fifo_rd   = feed && en;
  assign bus.arr_din_vld  = feed && en;
  assign bus.arr_din      = feed ? bus.in_fifo_dout : '0;
  assign bus.out_fifo_wr  = en && vld_sr_q[ARRAY_LAT-1];
  assign bus.out_fifo_din = busy ? bus.arr_dout : '0;
  assign done             = done_q;

  always_comb begin
    state_d   = state_q;
    m_last_d  = m_last_q;
    fed_cnt_d = fed_cnt_q;
    vld_sr_d  = vld_sr_q;
    done_d    = 1'b0;
    if (abort) begin
      state_d   = S_IDLE;
      fed_cnt_d = '0;
      vld_sr_d  = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d   = S_FEED;
            m_last_d  = M_minus_one;
            fed_cnt_d = '0;
            vld_sr_d  = '0;
          end
        end
        S_FEED: begin
          if (en) begin
            vld_sr_d = vld_shift;
            if (fed_cnt_q == m_last_q) begin
              state_d = S_DRAIN;
            end else begin
              fed_cnt_d = fed_cnt_q + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          if (en) begin
            vld_sr_d = vld_shift;
            if (vld_shift == '0) begin
              state_d = S_IDLE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      m_last_q  <= '0;
      fed_cnt_q <= '0;
      vld_sr_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_last_q  <= m_last_d;
      fed_cnt_q <= fed_cnt_d;
      vld_sr_q  <= vld_sr_d;
      done_q    <= done_d;
    end
  end

`ifdef SA_SEQ_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (accept) begin
      stall_d = '0;
    end else if (busy && !en && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt = stall_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
  assign stall_cnt     = '0;
`endif

endmodule

// File: tb/tb_sa_sequencer.sv
// tb_sa_sequencer: directed self-checking bench for sa_sequencer with
// behavioural input FIFO, array delay line and output FIFO logger.
module tb_sa_sequencer;

  localparam int BW  = 64;
  localparam int LAT = 8;
  localparam logic [BW-1:0] XMASK = 64'hFF00_F0F0_0F0F_00FF;

  logic        sys_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  m_in = '0;
  logic        busy;
  logic        done;
  logic [15:0] stall_cnt;

  sa_seq_if #(.BW(BW)) bus ();

  sa_sequencer #(
    .DIN_WIDTH(8), .N(4), .BUS_WIDTH(BW), .ARRAY_LAT(LAT)
  ) dut (
    .sys_clk    (sys_clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .M_minus_one(m_in),
    .busy       (busy),
    .done       (done),
    .stall_cnt  (stall_cnt),
    .bus        (bus)
  );

  always #5 sys_clk = ~sys_clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [BW-1:0] in_mem  [512];
  logic [BW-1:0] out_mem [512];
  logic [BW-1:0] pipe    [LAT] = '{default: '0};
  int   in_wr = 0;
  int   in_rd = 0;
  logic starve = 1'b0;
  logic out_full = 1'b0;
  logic env_clr = 1'b0;
  int   out_cnt = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   rd_first = -1;
  int   rd_last = -1;
  int   wr_first = -1;
  int   done_cyc = -1;
  int   start_cyc = -1;

  assign bus.in_fifo_empty = starve || (in_rd == in_wr);
  assign bus.in_fifo_dout  = in_mem[in_rd[8:0]];
  assign bus.arr_dout      = pipe[LAT-1] ^ XMASK;
  assign bus.out_fifo_full = out_full;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (bus.arr_en) begin
      pipe[0] <= bus.arr_din_vld ? bus.arr_din : '0;
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    if (env_clr) begin
      in_rd     <= 0;
      out_cnt   <= 0;
      done_cnt  <= 0;
      rd_first  <= -1;
      rd_last   <= -1;
      wr_first  <= -1;
      done_cyc  <= -1;
      start_cyc <= -1;
    end else begin
      if (bus.in_fifo_rd) begin
        in_rd   <= in_rd + 1;
        rd_last <= cyc;
        if (rd_first < 0) rd_first <= cyc;
      end
      if (bus.out_fifo_wr) begin
        out_mem[out_cnt[8:0]] <= bus.out_fifo_din;
        out_cnt <= out_cnt + 1;
        if (wr_first < 0) wr_first <= cyc;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_cyc <= cyc;
      end
      if (start && !busy && start_cyc < 0) start_cyc <= cyc;
    end
  end

  function automatic logic [BW-1:0] row_val(input logic [7:0] tag,
                                            input int i);
    return {16'hC0DE, tag, 8'h5A, i[31:0]};
  endfunction

  task automatic clear_env();
    in_wr   = 0;
    env_clr = 1'b1;
    @(negedge sys_clk);
    env_clr = 1'b0;
  endtask

  task automatic load_rows(input logic [7:0] tag, input int n);
    for (int i = 0; i < n; i++) in_mem[(in_wr + i) % 512] = row_val(tag, i);
    in_wr = in_wr + n;
  endtask

  task automatic go(input logic [7:0] m);
    start = 1'b1;
    m_in  = m;
    @(negedge sys_clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      @(negedge sys_clk);
      if (done_cnt > 0) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    load_rows(8'h01, 2);
    repeat (2) @(negedge sys_clk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_busy: got %b exp 0", busy);
    end
    n_tests++;
    if (done !== 1'b0) begin
      n_fail++; $display("FAIL reset_done: got %b exp 0", done);
    end
    n_tests++;
    if (bus.arr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_arr_en: got %b exp 0", bus.arr_en);
    end
    n_tests++;
    if (bus.in_fifo_rd !== 1'b0 || bus.arr_din_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rd_vld: got %b%b exp 00",
               bus.in_fifo_rd, bus.arr_din_vld);
    end
    n_tests++;
    if (bus.out_fifo_wr !== 1'b0) begin
      n_fail++; $display("FAIL reset_wr: got %b exp 0", bus.out_fifo_wr);
    end
    n_tests++;
    if (bus.arr_din !== '0 || bus.out_fifo_din !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got %h/%h exp 0/0",
               bus.arr_din, bus.out_fifo_din);
    end
    n_tests++;
    if (stall_cnt !== 16'd0) begin
      n_fail++; $display("FAIL reset_stall: got %0d exp 0", stall_cnt);
    end
    rst_n = 1'b1;
    @(negedge sys_clk);
    clear_env();
  endtask

  task automatic test_basic();
    bit ok;
    int errs = 0;
    clear_env();
    load_rows(8'h10, 4);
    go(8'd3);
    wait_done(100, ok);
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL basic_timeout: got no done exp done");
    end
    n_tests++;
    if (rd_first - start_cyc !== 1) begin
      n_fail++;
      $display("FAIL basic_start_lat: got %0d exp 1", rd_first - start_cyc);
    end
    n_tests++;
    if (in_rd !== 4 || rd_last - rd_first !== 3) begin
      n_fail++;
      $display("FAIL basic_pops: got %0d span %0d exp 4 span 3",
               in_rd, rd_last - rd_first);
    end
    n_tests++;
    if (wr_first - rd_first !== 8) begin
      n_fail++;
      $display("FAIL basic_wr_lat: got %0d exp 8", wr_first - rd_first);
    end
    n_tests++;
    if (done_cyc - rd_first !== 12) begin
      n_fail++;
      $display("FAIL basic_done_lat: got %0d exp 12", done_cyc - rd_first);
    end
    for (int i = 0; i < 4; i++)
      if (out_mem[i] !== (row_val(8'h10, i) ^ XMASK)) errs++;
    n_tests++;
    if (out_cnt !== 4 || errs !== 0) begin
      n_fail++;
      $display("FAIL basic_data: got %0d writes %0d bad exp 4 writes 0 bad",
               out_cnt, errs);
    end
    repeat (3) @(negedge sys_clk);
    n_tests++;
    if (busy !== 1'b0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL basic_end: got busy %b done %0d exp busy 0 done 1",
               busy, done_cnt);
    end
  endtask

  task automatic test_min_len();
    bit ok;
    clear_env();
    load_rows(8'h20, 2);
    go(8'd0);
    wait_done(100, ok);
    repeat (3) @(negedge sys_clk);
    n_tests++;
    if (in_rd !== 1 || out_cnt !== 1) begin
      n_fail++;
      $display("FAIL min_counts: got %0d pops %0d writes exp 1 1",
               in_rd, out_cnt);
    end
    n_tests++;
    if (out_mem[0] !== (row_val(8'h20, 0) ^ XMASK)) begin
      n_fail++;
      $display("FAIL min_data: got %h exp %h", out_mem[0],
               row_val(8'h20, 0) ^ XMASK);
    end
    n_tests++;
    if (done_cnt !== 1 || done_cyc - rd_first !== 9) begin
      n_fail++;
      $display("FAIL min_done: got %0d pulses lat %0d exp 1 lat 9",
               done_cnt, done_cyc - rd_first);
    end
  endtask

  task automatic test_max_len();
    bit ok;
    int errs = 0;
    clear_env();
    load_rows(8'h30, 260);
    go(8'd255);
    wait_done(400, ok);
    repeat (3) @(negedge sys_clk);
    n_tests++;
    if (!ok || in_rd !== 256 || out_cnt !== 256) begin
      n_fail++;
      $display("FAIL max_counts: got %0d pops %0d writes exp 256 256",
               in_rd, out_cnt);
    end
    for (int i = 0; i < 256; i++)
      if (out_mem[i] !== (row_val(8'h30, i) ^ XMASK)) errs++;
    n_tests++;
    if (errs !== 0) begin
      n_fail++; $display("FAIL max_data: got %0d bad exp 0", errs);
    end
    n_tests++;
    if (done_cyc - rd_first !== 264) begin
      n_fail++;
      $display("FAIL max_done_lat: got %0d exp 264", done_cyc - rd_first);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int errs = 0;
    logic [15:0] exp_stall;
`ifdef SA_SEQ_STALL_CNT_EN
    exp_stall = 16'd8;
`else
    exp_stall = 16'd0;
`endif
    clear_env();
    load_rows(8'h40, 8);
    go(8'd7);
    repeat (2) @(negedge sys_clk);
    starve = 1'b1;
    repeat (3) @(negedge sys_clk);
    starve = 1'b0;
    repeat (4) @(negedge sys_clk);
    out_full = 1'b1;
    #1;
    n_tests++;
    if (bus.arr_en !== 1'b0 || bus.in_fifo_rd !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_freeze: got en %b rd %b exp 0 0",
               bus.arr_en, bus.in_fifo_rd);
    end
    repeat (5) @(negedge sys_clk);
    out_full = 1'b0;
    wait_done(100, ok);
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 8; i++)
      if (out_mem[i] !== (row_val(8'h40, i) ^ XMASK)) errs++;
    n_tests++;
    if (!ok || in_rd !== 8 || out_cnt !== 8 || errs !== 0) begin
      n_fail++;
      $display("FAIL bp_data: got %0d pops %0d writes %0d bad exp 8 8 0",
               in_rd, out_cnt, errs);
    end
    n_tests++;
    if (done_cyc - rd_first !== 24) begin
      n_fail++;
      $display("FAIL bp_done_lat: got %0d exp 24", done_cyc - rd_first);
    end
    n_tests++;
    if (stall_cnt !== exp_stall) begin
      n_fail++;
      $display("FAIL bp_stall_cnt: got %0d exp %0d", stall_cnt, exp_stall);
    end
  endtask

  task automatic test_abort();
    bit ok;
    bit hit = 1'b0;
    int errs = 0;
    clear_env();
    load_rows(8'h50, 4);
    go(8'd3);
    for (int k = 0; k < 40; k++) begin
      if (out_cnt >= 2) begin
        hit = 1'b1;
        break;
      end
      @(negedge sys_clk);
    end
    abort = 1'b1;
    #1;
    n_tests++;
    if (!hit || bus.out_fifo_wr !== 1'b0 || bus.arr_en !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_gate: got hit %b wr %b en %b exp 1 0 0",
               hit, bus.out_fifo_wr, bus.arr_en);
    end
    @(negedge sys_clk);
    abort = 1'b0;
    repeat (15) @(negedge sys_clk);
    n_tests++;
    if (out_cnt !== 2 || done_cnt !== 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_state: got %0d writes %0d done busy %b exp 2 0 0",
               out_cnt, done_cnt, busy);
    end
    clear_env();
    load_rows(8'h51, 2);
    go(8'd1);
    wait_done(100, ok);
    repeat (3) @(negedge sys_clk);
    for (int i = 0; i < 2; i++)
      if (out_mem[i] !== (row_val(8'h51, i) ^ XMASK)) errs++;
    n_tests++;
    if (!ok || out_cnt !== 2 || errs !== 0 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL abort_restart: got %0d writes %0d bad %0d done exp 2 0 1",
               out_cnt, errs, done_cnt);
    end
  endtask

  task automatic test_reset_mid_job();
    clear_env();
    load_rows(8'h60, 4);
    go(8'd3);
    @(negedge sys_clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (busy !== 1'b0 || bus.arr_en !== 1'b0 || bus.in_fifo_rd !== 1'b0 ||
        bus.arr_din_vld !== 1'b0 || bus.arr_din !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_outs: got busy %b en %b rd %b vld %b din %h exp 0",
               busy, bus.arr_en, bus.in_fifo_rd, bus.arr_din_vld, bus.arr_din);
    end
    n_tests++;
    if (out_cnt !== 0 || done !== 1'b0 || stall_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_mid_misc: got %0d writes done %b stall %0d exp 0 0 0",
               out_cnt, done, stall_cnt);
    end
    @(negedge sys_clk);
    rst_n = 1'b1;
    @(negedge sys_clk);
  endtask

  task automatic test_start_while_busy();
    bit ok;
    clear_env();
    load_rows(8'h70, 6);
    go(8'd3);
    @(negedge sys_clk);
    go(8'd0);
    wait_done(100, ok);
    repeat (3) @(negedge sys_clk);
    n_tests++;
    if (!ok || in_rd !== 4 || out_cnt !== 4 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL busy_start: got %0d pops %0d writes %0d done exp 4 4 1",
               in_rd, out_cnt, done_cnt);
    end
    n_tests++;
    if (done_cyc - rd_first !== 12) begin
      n_fail++;
      $display("FAIL busy_start_lat: got %0d exp 12", done_cyc - rd_first);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_len();
    test_max_len();
    test_backpressure();
    test_abort();
    test_reset_mid_job();
    test_start_while_busy();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
